// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/MEM memory-port arbiter.
// State encodings are fixed 2-bit constants so existing waveform decoders still apply.
package mem_arb_pkg;

    typedef logic [1:0] stateT;
    localparam stateT IDLE   = 2'd0;
    localparam stateT BUSY_I = 2'd1;
    localparam stateT BUSY_D = 2'd2;
    localparam stateT RESP   = 2'd3;

    typedef logic reqIdT;
    localparam reqIdT REQ_I = 1'b0;
    localparam reqIdT REQ_D = 1'b1;

    // Watchdog counter width for a given TIMEOUT.
    function automatic int unsigned toW(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

    function automatic stateT busyState(input reqIdT id);
        return (id == REQ_D) ? BUSY_D : BUSY_I;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-cycle counter for the arbiter; flags expiry once TIMEOUT-1 idle-waiting cycles elapsed.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TO_W = toW(TIMEOUT);
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch and data access.
// Optional abort on a stuck memory is enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    if (TIMEOUT < 2) begin : gBadTimeout
        $error("mem_port_arbiter: TIMEOUT must be >= 2");
    end

    stateT state;
    reqIdT grantId;
    logic  busy;
    logic  abort;

    assign grantId = d_req_i ? REQ_D : REQ_I;
    assign busy    = (state == BUSY_I) || (state == BUSY_D);
    assign stall_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
        .clk     (clk_i),
        .rstN    (rst_i),
        .clear   (state == IDLE),
        .enable  (busy & ~mem_ack_i),
        .expired (expired)
    );

    // A memory ack in the expiry cycle wins: normal completion, no error.
    assign abort = expired & ~mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= busy & abort;
        end
    end
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            i_ack_o     <= 1'b0;
            d_ack_o     <= 1'b0;
            i_rdata_o   <= '0;
            d_rdata_o   <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            i_ack_o <= 1'b0;
            d_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req_i || i_req_i) begin
                        state       <= busyState(grantId);
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_req_i & d_we_i;
                        mem_addr_o  <= d_req_i ? d_addr_i : i_addr_i;
                        mem_wdata_o <= d_req_i ? d_wdata_i : '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Ack and rdata are registered on the way into RESP so they appear there together.
                    if (mem_ack_i || abort) begin
                        state     <= RESP;
                        mem_req_o <= 1'b0;
                        if (state == BUSY_I) begin
                            i_ack_o   <= 1'b1;
                            i_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end else begin
                            d_ack_o   <= 1'b1;
                            d_rdata_o <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
